// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment driver: sequential double-dabble binary-to-BCD
// conversion feeding a continuously scanned, registered anode/segment output.
module sseg_scan_driver #(
  parameter int DIGITS      = 5,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 65536,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        sseg,
  output logic              dp
);

  // Number of decimal digits needed for 2^w - 1.
  function automatic int calc_bcd_n(input int w);
    logic [63:0] v;
    int          n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  localparam int BCD_N = calc_bcd_n(DATA_W);
  localparam int SCR_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int SCR_W = 4 * SCR_N;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit INV   = (ACTIVE_LOW != 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]          state;
  logic [DATA_W-1:0]   shreg;
  logic [SCR_W-1:0]    scratch;
  logic [SCR_W-1:0]    scratch_adj;
  logic [CNT_W-1:0]    bit_cnt;
  logic [4*DIGITS-1:0] disp;
  logic                high_nz;

  always_comb begin
    scratch_adj = scratch;
    for (int n = 0; n < SCR_N; n++) begin
      if (scratch[4*n +: 4] >= 4'd5) scratch_adj[4*n +: 4] = scratch[4*n +: 4] + 4'd3;
    end
  end

  // Scratch nibbles above the display width mean the value did not fit.
  always_comb begin
    high_nz = 1'b0;
    for (int n = DIGITS; n < SCR_N; n++) high_nz = high_nz | (|scratch[4*n +: 4]);
  end

  // Handshake: load is a one-cycle request, accepted only when busy is low;
  // requests while busy are dropped, and done marks the commit of the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      scratch  <= '0;
      bit_cnt  <= '0;
      disp     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            shreg   <= value;
            scratch <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          scratch <= {scratch_adj[SCR_W-2:0], shreg[DATA_W-1]};
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          disp     <= scratch[4*DIGITS-1:0];
          overflow <= high_nz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] scan_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
      div_cnt  <= '0;
      scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // zero_from[i]: digits i..DIGITS-1 of the display register are all zero.
  logic [DIGITS-1:0] zero_from;
  logic              zero_run;

  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (disp[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end

  logic [DIGITS-1:0] an_oh;
  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic              cur_dp;
  logic [6:0]        seg_raw;

  always_comb begin
    an_oh     = '0;
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        an_oh[i]  = 1'b1;
        cur_nib   = disp[4*i +: 4];
        cur_blank = (i != 0) && zero_from[i];
        cur_dp    = dp_mask[i];
      end
    end
  end

  always_comb begin
    if (overflow)                   seg_raw = 7'h40;
    else if (blank_lz && cur_blank) seg_raw = 7'h00;
    else                            seg_raw = seg_decode(cur_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= {DIGITS{INV}};
      sseg <= {7{INV}};
      dp   <= INV;
    end else begin
      an   <= an_oh ^ {DIGITS{INV}};
      sseg <= seg_raw ^ {7{INV}};
      dp   <= cur_dp ^ INV;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: a 5-digit and a 4-digit instance share stimulus;
// committed values are scoreboarded on done and the scan is checked per sample.
module tb_sseg_scan_driver;
  localparam int DW   = 16;
  localparam int RDIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          blank_lz;
  logic [DW-1:0] value;
  logic [4:0]    dp_mask;
  logic [3:0]    dp_mask4;

  logic       busy, done, overflow, dp;
  logic [4:0] an;
  logic [6:0] sseg;
  logic       busy4, done4, overflow4, dp4;
  logic [3:0] an4;
  logic [6:0] sseg4;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  assign dp_mask4 = dp_mask[3:0];

  always #5 clk = ~clk;

  sseg_scan_driver #(.DIGITS(5), .DATA_W(DW), .REFRESH_DIV(RDIV), .ACTIVE_LOW(1)) u_dut5 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .busy(busy), .done(done), .overflow(overflow),
    .an(an), .sseg(sseg), .dp(dp)
  );

  sseg_scan_driver #(.DIGITS(4), .DATA_W(DW), .REFRESH_DIV(RDIV), .ACTIVE_LOW(1)) u_dut4 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_mask(dp_mask4),
    .blank_lz(blank_lz), .busy(busy4), .done(done4), .overflow(overflow4),
    .an(an4), .sseg(sseg4), .dp(dp4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Active-high expected segments for digit i of v on an nd-digit display.
  function automatic logic [6:0] seg_model(input int unsigned v, input int i, input bit blz, input int nd);
    int unsigned p, lim;
    logic [6:0]  s;
    p = 1;
    lim = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    if (v >= lim) s = 7'h40;
    else if (blz && i > 0 && v < p) s = 7'h00;
    else begin
      case ((v / p) % 10)
        0: s = 7'h3F;
        1: s = 7'h06;
        2: s = 7'h5B;
        3: s = 7'h4F;
        4: s = 7'h66;
        5: s = 7'h6D;
        6: s = 7'h7D;
        7: s = 7'h07;
        8: s = 7'h7F;
        default: s = 7'h6F;
      endcase
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [DW-1:0] v, input bit accept);
    value = v;
    load = 1'b1;
    if (accept) exp_q.push_back(v);
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input int exp_busy);
    int       busy_cnt;
    bit       seen;
    logic [DW-1:0] v;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end else begin
      checks++;
      if (busy_cnt != exp_busy) begin
        errors++;
        $display("FAIL busy_len: got %0d cycles, want %0d", busy_cnt, exp_busy);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done: got %b, want 0", busy);
      end
      checks++;
      if (done4 !== 1'b1) begin
        errors++;
        $display("FAIL done4_align: got %b, want 1", done4);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: scoreboard empty");
      end else begin
        v = exp_q.pop_front();
        checks++;
        if (overflow !== (v >= 100000)) begin
          errors++;
          $display("FAIL overflow5 v=%0d: got %b, want %b", v, overflow, (v >= 100000));
        end
        checks++;
        if (overflow4 !== (v >= 10000)) begin
          errors++;
          $display("FAIL overflow4 v=%0d: got %b, want %b", v, overflow4, (v >= 10000));
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse_width: got %b, want 0", done);
      end
    end
  endtask

  task automatic scan_check5(input int unsigned v, input bit blz, input logic [4:0] dpm, input int ncyc);
    int prev, run;
    bit first_run;
    prev = -1;
    run = 0;
    first_run = 1'b1;
    tick();
    tick();
    for (int k = 0; k < ncyc; k++) begin
      logic [4:0] act;
      int i;
      @(negedge clk);
      act = ~an;
      i = -1;
      for (int j = 0; j < 5; j++) if (act == (5'b1 << j)) i = j;
      checks++;
      if (i < 0) begin
        errors++;
        $display("FAIL scan5_onehot: an=%b", an);
      end else begin
        checks++;
        if (sseg !== ~seg_model(v, i, blz, 5)) begin
          errors++;
          $display("FAIL scan5_seg v=%0d digit=%0d: got %b, want %b", v, i, sseg, ~seg_model(v, i, blz, 5));
        end
        checks++;
        if (dp !== ~dpm[i]) begin
          errors++;
          $display("FAIL scan5_dp digit=%0d: got %b, want %b", i, dp, ~dpm[i]);
        end
        if (i != prev) begin
          if (prev >= 0) begin
            checks++;
            if (i != (prev + 1) % 5) begin
              errors++;
              $display("FAIL scan5_order: got digit %0d after %0d, want %0d", i, prev, (prev + 1) % 5);
            end
            if (!first_run) begin
              checks++;
              if (run != RDIV) begin
                errors++;
                $display("FAIL scan5_slot_len digit=%0d: got %0d, want %0d", prev, run, RDIV);
              end
            end
            first_run = 1'b0;
          end
          prev = i;
          run = 1;
        end else begin
          run++;
        end
      end
    end
  endtask

  task automatic scan_check4(input int unsigned v, input bit blz, input int ncyc);
    tick();
    tick();
    for (int k = 0; k < ncyc; k++) begin
      logic [3:0] act;
      int i;
      @(negedge clk);
      act = ~an4;
      i = -1;
      for (int j = 0; j < 4; j++) if (act == (4'b1 << j)) i = j;
      checks++;
      if (i < 0) begin
        errors++;
        $display("FAIL scan4_onehot: an4=%b", an4);
      end else begin
        checks++;
        if (sseg4 !== ~seg_model(v, i, blz, 4)) begin
          errors++;
          $display("FAIL scan4_seg v=%0d digit=%0d: got %b, want %b", v, i, sseg4, ~seg_model(v, i, blz, 4));
        end
        checks++;
        if (dp4 !== ~dp_mask[i]) begin
          errors++;
          $display("FAIL scan4_dp digit=%0d: got %b, want %b", i, dp4, ~dp_mask[i]);
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: busy=%b done=%b overflow=%b, want 0 0 0", tag, busy, done, overflow);
    end
    checks++;
    if (an !== 5'h1F || an4 !== 4'hF) begin
      errors++;
      $display("FAIL %s_an: an=%b an4=%b, want all 1", tag, an, an4);
    end
    checks++;
    if (sseg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL %s_seg: sseg=%b dp=%b, want 1111111 1", tag, sseg, dp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load = 1'b0;
    value = '0;
    blank_lz = 1'b0;
    dp_mask = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_convert();
    blank_lz = 1'b0;
    dp_mask = '0;
    drive_load(16'd12345, 1'b1);
    wait_done(DW + 1);
    scan_check5(12345, 1'b0, 5'b00000, 2 * 5 * RDIV + 4);
  endtask

  task automatic test_blanking();
    blank_lz = 1'b1;
    drive_load(16'd7, 1'b1);
    wait_done(DW + 1);
    scan_check5(7, 1'b1, 5'b00000, 2 * 5 * RDIV + 4);
    blank_lz = 1'b0;
    scan_check5(7, 1'b0, 5'b00000, 2 * 5 * RDIV + 4);
  endtask

  task automatic test_overflow();
    blank_lz = 1'b0;
    drive_load(16'd65535, 1'b1);
    wait_done(DW + 1);
    scan_check4(65535, 1'b0, 2 * 4 * RDIV + 4);
    blank_lz = 1'b1;
    scan_check4(65535, 1'b1, 4 * RDIV);
    scan_check5(65535, 1'b1, 5'b00000, 2 * 5 * RDIV + 4);
    blank_lz = 1'b0;
    drive_load(16'd42, 1'b1);
    wait_done(DW + 1);
    scan_check4(42, 1'b0, 2 * 4 * RDIV + 4);
    blank_lz = 1'b1;
    scan_check4(42, 1'b1, 2 * 4 * RDIV + 4);
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    int extra;
    drive_load(16'd100, 1'b1);
    tick();
    tick();
    drive_load(16'd999, 1'b0);
    wait_done(DW + 1 - 3);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_load_done: got %0d extra done pulses, want 0", extra);
    end
    scan_check5(100, 1'b0, 5'b00000, 2 * 5 * RDIV + 4);
  endtask

  task automatic test_reset_mid();
    int stray;
    blank_lz = 1'b1;
    drive_load(16'd54321, 1'b1);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    check_idle_outputs("reset_mid");
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_activity: got %0d busy/done cycles, want 0", stray);
    end
    scan_check5(0, 1'b1, 5'b00000, 2 * 5 * RDIV + 4);
    blank_lz = 1'b0;
    scan_check5(0, 1'b0, 5'b00000, 2 * 5 * RDIV + 4);
  endtask

  task automatic test_dp();
    blank_lz = 1'b0;
    dp_mask = 5'b00100;
    drive_load(16'd314, 1'b1);
    wait_done(DW + 1);
    scan_check5(314, 1'b0, 5'b00100, 2 * 5 * RDIV + 4);
    blank_lz = 1'b1;
    dp_mask = 5'b10000;
    scan_check5(314, 1'b1, 5'b10000, 2 * 5 * RDIV + 4);
    dp_mask = $urandom_range(0, 31);
    scan_check5(314, 1'b1, dp_mask, 2 * 5 * RDIV + 4);
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    blank_lz = 1'b0;
    dp_mask = '0;
    for (int n = 0; n < 4; n++) begin
      v = DW'($urandom_range(0, 65535));
      blank_lz = n[0];
      drive_load(v, 1'b1);
      wait_done(DW + 1);
      scan_check5(v, blank_lz, 5'b00000, 2 * 5 * RDIV + 4);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_dp();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Parametrised multiplexed seven-segment driver; next generation of the team's 5-digit display block.
- Binary input converted to BCD by a sequential double-dabble engine, not combinational / and %.
- Adds: configurable digit count and refresh rate, load handshake, leading-zero blanking, per-digit decimal points, and an overflow indication.
- Sits between application logic (score, timer, counter values) and the board's anode/segment pins.

Parameters:
- DIGITS, 5, number of multiplexed digits (1..8).
- DATA_W, 16, width of the binary input value.
- REFRESH_DIV, 65536, clk cycles per digit slot (>=2).
- ACTIVE_LOW, 1, 1: anodes, segments and dp active-low; 0: active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- value  in  DATA_W  unsigned binary value to display.
- load  in  1  one-cycle request to capture value.
- dp_mask  in  DIGITS  decimal point per digit; bit i = digit i, i=0 least significant. Sampled live.
- blank_lz  in  1  1 = suppress leading zeros.
- busy  out  1  conversion in progress; load ignored while high.
- done  out  1  one-cycle pulse when the new value is committed to the display.
- overflow  out  1  sticky per committed value; set when value >= 10^DIGITS.
- an  out  DIGITS  digit enables, one-hot in polarity per ACTIVE_LOW.
- sseg  out  7  segments a..g; sseg[0]=a ... sseg[6]=g.
- dp  out  1  decimal point of the currently enabled digit.

Behaviour:
- Reset, synchronous, applied at the next clk edge:
  - an, sseg and dp all inactive.
  - busy=0, done=0, overflow=0.
  - Committed BCD = 0; scan index = 0; divider = 0; FSM = IDLE.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - load=1 captures value into the shift register and clears the BCD scratch.
  - Next state CONVERT; busy=1 from the next cycle.
- CONVERT:
  - Runs exactly DATA_W cycles.
  - Each cycle: add 3 to every scratch BCD nibble >=5, then shift left 1, bringing in the MSB of the shift register.
  - Scratch width is the number of nibbles covering 2^DATA_W-1, which may exceed DIGITS.
  - After DATA_W cycles, go to COMMIT.
- COMMIT (one cycle):
  - Copy the low DIGITS nibbles to the display register atomically.
  - Set overflow if any higher nibble is non-zero, else clear it.
  - Pulse done=1, drop busy, return to IDLE.
- Latency: load at edge t gives busy high for cycles t+1..t+DATA_W+1; done and the new display register take effect at t+DATA_W+1. Total DATA_W+1 cycles.
- load while busy is ignored: no queueing, no abort.
- Reset mid-conversion aborts the conversion. The display returns to 0; no done pulse is issued.
- Scan:
  - Divider counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0,1,...,DIGITS-1,0.
  - an, sseg and dp are registered from the index and the display register, so they update one cycle after the index.
  - Exactly one anode is active at any time after the first post-reset slot update.
- Digit decode: 0-9 standard patterns.
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=all, 9=abcdfg.
  - Polarity per ACTIVE_LOW.
- Leading-zero blanking, when blank_lz=1:
  - Digit i>0 is blanked (all segments off) if digits i..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking does not affect dp; dp follows dp_mask[index].
- Overflow display: while overflow=1, every digit shows "-" (segment g only). Blanking is ignored.
- The display register changes only in COMMIT. The scan runs continuously and is unaffected by conversion.

Test Plan:
1. DIGITS=5, DATA_W=16, REFRESH_DIV=4. Reset, then load value=12345 → busy high 17 cycles, done pulse at cycle 17. Over one scan period, sseg shows 5,4,3,2,1 with an=11110,11101,11011,10111,01111, each held 4 cycles.
2. load value=7 with blank_lz=1 → digit0 shows "7" (abc active); digits 1-4 all segments off. With blank_lz=0 → digits 1-4 show "0".
3. DIGITS=4, load value=65535 → overflow=1; all four digits show segment g only. Then load 42 → overflow=0; display shows 0042 (or __42 with blanking).
4. Load 100 and, 3 cycles later, load 999 while busy → 999 is ignored. One done pulse; display shows 100.
5. Assert rst in the 8th CONVERT cycle → next edge: busy=0, an all off, no done. After release, the scan shows 0 on digit0.
6. dp_mask=00100, value=314 → dp active only while an selects digit 2; other slots dp inactive.
